// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpnew_pkg
//  Purpose  : Shared FPnew types and helpers: floating-point and integer
//             format encodings, width/bias queries, rounding modes and the
//             IEEE exception status flags.
//  Revision : 1.0  initial release
// ============================================================================
package fpnew_pkg;

    typedef struct packed {
        int unsigned exp_bits;
        int unsigned man_bits;
    } fp_encoding_t;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam int unsigned FP_FORMAT_BITS = $clog2(NUM_FP_FORMATS);

    typedef enum logic [FP_FORMAT_BITS-1:0] {
        FP32    = 'd0,
        FP64    = 'd1,
        FP16    = 'd2,
        FP8     = 'd3,
        FP16ALT = 'd4
    } fp_format_e;

    localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
        '{8,  23},
        '{11, 52},
        '{5,  10},
        '{5,  2},
        '{8,  7}
    };

    typedef enum logic [1:0] {
        INT8,
        INT16,
        INT32,
        INT64
    } int_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    function automatic int unsigned exp_bits(fp_format_e fmt);
        return FP_ENCODINGS[fmt].exp_bits;
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        return FP_ENCODINGS[fmt].man_bits;
    endfunction

    function automatic int unsigned fp_width(fp_format_e fmt);
        return FP_ENCODINGS[fmt].exp_bits + FP_ENCODINGS[fmt].man_bits + 1;
    endfunction

    function automatic int unsigned bias(fp_format_e fmt);
        return unsigned'(2**(FP_ENCODINGS[fmt].exp_bits - 1) - 1);
    endfunction

    function automatic int unsigned int_width(int_format_e ifmt);
        case (ifmt)
            INT8:    return 8;
            INT16:   return 16;
            INT32:   return 32;
            INT64:   return 64;
            default: return 0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_rounding.sv
`default_nettype none
// ============================================================================
//  Module   : fpnew_rounding
//  Purpose  : Applies an IEEE rounding decision to a sign/magnitude value.
//  Ports    : abs_value_i          - unrounded magnitude (exp|mantissa)
//             sign_i               - sign of the value
//             round_sticky_bits_i  - {round, sticky}
//             rnd_mode_i           - rounding mode
//             effective_subtraction_i - selects sign of an exact-zero sum
//             abs_rounded_o        - rounded magnitude
//             sign_o / exact_zero_o - result sign, exact-zero indicator
//  Revision : 1.0  initial release
// ============================================================================
module fpnew_rounding
    import fpnew_pkg::*;
#(
    parameter int unsigned AbsWidth = 2
) (
    input  logic [AbsWidth-1:0] abs_value_i,
    input  logic                sign_i,
    input  logic [1:0]          round_sticky_bits_i,
    input  roundmode_e          rnd_mode_i,
    input  logic                effective_subtraction_i,
    output logic [AbsWidth-1:0] abs_rounded_o,
    output logic                sign_o,
    output logic                exact_zero_o
);

    logic w_round_up;

    always_comb begin
        w_round_up = 1'b0;
        case (rnd_mode_i)
            RNE: begin
                case (round_sticky_bits_i)
                    2'b10:   w_round_up = abs_value_i[0];   // tie: to even
                    2'b11:   w_round_up = 1'b1;
                    default: w_round_up = 1'b0;
                endcase
            end
            RTZ:     w_round_up = 1'b0;
            RDN:     w_round_up = (|round_sticky_bits_i) ? sign_i  : 1'b0;
            RUP:     w_round_up = (|round_sticky_bits_i) ? ~sign_i : 1'b0;
            RMM:     w_round_up = round_sticky_bits_i[1];
            default: w_round_up = 1'b0;
        endcase
    end

    // A mantissa carry ripples into the exponent field, which is exactly the
    // desired behaviour for the packed exp|mantissa encoding.
    assign abs_rounded_o = abs_value_i + AbsWidth'(w_round_up);
    assign exact_zero_o  = (abs_value_i == '0) && (round_sticky_bits_i == 2'b00);
    assign sign_o        = (exact_zero_o && effective_subtraction_i)
                         ? (rnd_mode_i == RDN) : sign_i;

endmodule
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
//  Module   : lzc
//  Purpose  : Leading/trailing zero counter.
//  Ports    : in_i    - vector to scan
//             cnt_o   - number of zeros before the first set bit
//             empty_o - high when in_i is all zeros (cnt_o is then 0)
//  Revision : 1.0  initial release
// ============================================================================
module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,   // 0: trailing, 1: leading
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    // Scan from the far end towards the near end so the set bit closest to
    // the counting origin is the last one to write the result.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (in_i[MODE ? (int'(WIDTH) - 1 - i) : i]) begin
                cnt_o   = CNT_WIDTH'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpnew_i2fcast_iter.sv
`default_nettype none
// ============================================================================
//  Module   : fpnew_i2fcast_iter
//  Purpose  : Iterative integer-to-float conversion. The magnitude is
//             normalised at most ShiftStep bit positions per cycle, then
//             rounded in a single cycle and held until the consumer takes it.
//  Ports    : clk_i, rst_ni            - clock, async active-low reset
//             operand_i, is_signed_i   - source integer and its signedness
//             rnd_mode_i, tag_i        - rounding mode, opaque tag
//             in_valid_i / in_ready_o  - input handshake
//             flush_i                  - abort any in-flight operation
//             result_o, status_o       - converted value and IEEE flags
//             extension_bit_o          - NaN-boxing bit (constant 1)
//             tag_o                    - tag of the completed operation
//             out_valid_o / out_ready_i - output handshake
//             busy_o                   - operation in flight
//  Revision : 1.0  initial release
// ============================================================================
module fpnew_i2fcast_iter
    import fpnew_pkg::*;
#(
    parameter fpnew_pkg::fp_format_e  DstFpFormat = fpnew_pkg::fp_format_e'(0),
    parameter fpnew_pkg::int_format_e IntFormat   = fpnew_pkg::INT32,
    parameter int unsigned            ShiftStep   = 4,
    parameter type                    TagType     = logic,
    localparam int unsigned IntWidth  = fpnew_pkg::int_width(IntFormat),
    localparam int unsigned DST_WIDTH = fpnew_pkg::fp_width(DstFpFormat)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IntWidth-1:0]  operand_i,
    input  logic                 is_signed_i,
    input  roundmode_e           rnd_mode_i,
    input  TagType               tag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic                 flush_i,
    output logic [DST_WIDTH-1:0] result_o,
    output status_t              status_o,
    output logic                 extension_bit_o,
    output TagType               tag_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o
);

    localparam int unsigned DST_EXP_BITS = fpnew_pkg::exp_bits(DstFpFormat);
    localparam int unsigned DST_MAN_BITS = fpnew_pkg::man_bits(DstFpFormat);
    localparam int unsigned DST_BIAS     = fpnew_pkg::bias(DstFpFormat);
    localparam int unsigned ABS_W        = DST_WIDTH - 1;
    // Exponent counter must hold IntWidth-1 and survive a full-width step.
    localparam int unsigned EXPC_W       = $clog2(IntWidth) + 1;
    localparam int unsigned LZ_W         = (ShiftStep > 1) ? $clog2(ShiftStep) : 1;
    localparam int unsigned SH_W         = $clog2(ShiftStep + 1);
    // Fraction bits below the hidden one, padded so mantissa, round and one
    // sticky position always exist even for narrow integers.
    localparam int unsigned EXT_W        = IntWidth + DST_MAN_BITS + 1;
    localparam int unsigned BEXP_W       = ((EXPC_W > DST_EXP_BITS) ? EXPC_W : DST_EXP_BITS) + 1;

    localparam logic [BEXP_W-1:0] EXP_INF        = BEXP_W'((2**DST_EXP_BITS) - 1);
    localparam logic [ABS_W-1:0]  LARGEST_NORMAL = {DST_EXP_BITS'((2**DST_EXP_BITS) - 2),
                                                    {DST_MAN_BITS{1'b1}}};

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] NORM  = 2'd1;
    localparam logic [1:0] ROUND = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]           state_q,  state_d;
    logic [IntWidth-1:0]  mag_q,    mag_d;
    logic [EXPC_W-1:0]    exp_q,    exp_d;
    logic                 sign_q,   sign_d;
    roundmode_e           rnd_q,    rnd_d;
    TagType               tag_q,    tag_d;
    logic [DST_WIDTH-1:0] result_q, result_d;
    status_t              status_q, status_d;

    // ------------------------------------------------------------------
    // Input conditioning: two's-complement absolute value. The most
    // negative value negates onto itself, which read unsigned is 2^(W-1).
    // ------------------------------------------------------------------
    logic                w_in_sign;
    logic [IntWidth-1:0] w_in_mag;

    assign w_in_sign = is_signed_i & operand_i[IntWidth-1];
    assign w_in_mag  = w_in_sign ? (~operand_i + IntWidth'(1)) : operand_i;

    // ------------------------------------------------------------------
    // Normalisation step
    // ------------------------------------------------------------------
    logic [ShiftStep-1:0] w_window;
    logic [LZ_W-1:0]      w_lz;
    logic                 w_lz_empty;
    logic [SH_W-1:0]      w_shamt;

    assign w_window = mag_q[IntWidth-1 -: ShiftStep];

    lzc #(
        .WIDTH     (ShiftStep),
        .MODE      (1'b1),
        .CNT_WIDTH (LZ_W)
    ) i_lzc (
        .in_i    (w_window),
        .cnt_o   (w_lz),
        .empty_o (w_lz_empty)
    );

    // An all-zero window moves the full step and stays in NORM; otherwise
    // the leading one lands in the MSB and normalisation is complete.
    assign w_shamt = w_lz_empty ? SH_W'(ShiftStep) : SH_W'(w_lz);

    // ------------------------------------------------------------------
    // Rounding datapath (valid while in ROUND, MSB of mag_q is the hidden 1)
    // ------------------------------------------------------------------
    logic [EXT_W-1:0]        w_ext;
    logic [DST_MAN_BITS-1:0] w_mant;
    logic                    w_round_bit;
    logic                    w_sticky_bit;
    logic [BEXP_W-1:0]       w_bexp;
    logic                    w_of_before;
    logic [ABS_W-1:0]        w_pre_round;
    logic [1:0]              w_rs_bits;
    logic [ABS_W-1:0]        w_abs_rounded;
    logic                    w_rnd_sign;
    logic                    w_exact_zero;
    logic                    w_of_after;
    status_t                 w_status;

    assign w_ext        = {mag_q[IntWidth-2:0], {(DST_MAN_BITS + 2){1'b0}}};
    assign w_mant       = w_ext[EXT_W-1 -: DST_MAN_BITS];
    assign w_round_bit  = w_ext[EXT_W-1-DST_MAN_BITS];
    assign w_sticky_bit = |w_ext[EXT_W-2-DST_MAN_BITS:0];

    assign w_bexp      = BEXP_W'(exp_q) + BEXP_W'(DST_BIAS);
    assign w_of_before = (w_bexp >= EXP_INF);

    // Out-of-range exponents are presented to the rounder as the largest
    // normal with round and sticky set, so the mode decides between the
    // largest normal and infinity.
    assign w_pre_round = w_of_before ? LARGEST_NORMAL
                                     : {w_bexp[DST_EXP_BITS-1:0], w_mant};
    assign w_rs_bits   = w_of_before ? 2'b11 : {w_round_bit, w_sticky_bit};

    fpnew_rounding #(
        .AbsWidth (ABS_W)
    ) i_fpnew_rounding (
        .abs_value_i             (w_pre_round),
        .sign_i                  (sign_q),
        .round_sticky_bits_i     (w_rs_bits),
        .rnd_mode_i              (rnd_q),
        .effective_subtraction_i (1'b0),
        .abs_rounded_o           (w_abs_rounded),
        .sign_o                  (w_rnd_sign),
        .exact_zero_o            (w_exact_zero)
    );

    assign w_of_after = &w_abs_rounded[ABS_W-1 -: DST_EXP_BITS];

    always_comb begin
        w_status    = '0;
        w_status.OF = w_of_before | w_of_after;
        w_status.NX = (|w_rs_bits) | w_status.OF;
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        rnd_d    = rnd_q;
        tag_d    = tag_q;
        result_d = result_q;
        status_d = status_q;

        if (flush_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        sign_d = w_in_sign;
                        mag_d  = w_in_mag;
                        exp_d  = EXPC_W'(IntWidth - 1);
                        rnd_d  = rnd_mode_i;
                        tag_d  = tag_i;
                        if (w_in_mag == '0) begin
                            // Zero converts to +0 regardless of rounding mode.
                            result_d = '0;
                            status_d = '0;
                            state_d  = DONE;
                        end else begin
                            state_d  = NORM;
                        end
                    end
                end
                NORM: begin
                    mag_d = mag_q << w_shamt;
                    exp_d = exp_q - EXPC_W'(w_shamt);
                    if (!w_lz_empty) begin
                        state_d = ROUND;
                    end
                end
                ROUND: begin
                    result_d = {w_rnd_sign & ~w_exact_zero, w_abs_rounded};
                    status_d = w_status;
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            mag_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            rnd_q    <= RNE;
            tag_q    <= '0;
            result_q <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            rnd_q    <= rnd_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            status_q <= status_d;
        end
    end

    assign in_ready_o      = (state_q == IDLE);
    assign busy_o          = (state_q != IDLE);
    assign out_valid_o     = (state_q == DONE);
    assign result_o        = result_q;
    assign status_o        = status_q;
    assign tag_o           = tag_q;
    assign extension_bit_o = 1'b1;

endmodule
`default_nettype wire
